// File: rtl/templatized_alu_pkg.sv
// Shared opcode, group-enable and FSM state definitions for the ALU decoder and exec stage.
// Pure definitions; no latency or backpressure of its own.
// Helper exp_en() maps an opcode to its one-hot group enable (000 for undefined opcodes).
package templatized_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LT  = 4'd2;
    localparam logic [3:0] OP_GT  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SAR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

    localparam logic [2:0] EN_ARITH = 3'b100;
    localparam logic [2:0] EN_LOGIC = 3'b010;
    localparam logic [2:0] EN_SHIFT = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [2:0] exp_en(input logic [3:0] op);
        logic [2:0] e;
        e = 3'b000;
        case (op)
            OP_ADD, OP_SUB, OP_LT, OP_GT:   e = EN_ARITH;
            OP_XOR:                         e = EN_LOGIC;
            OP_SLL, OP_SAR, OP_ROL, OP_ROR: e = EN_SHIFT;
            default:                        e = 3'b000;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/templatized_alu_exec_shift_step.sv
// One-bit SLL/SAR/ROL/ROR step on WIDTH bits, selected by opcode.
// Latency: combinational.
// Backpressure: none; non-shift opcodes pass the input through unchanged.
module templatized_alu_shift_step
    import templatized_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SAR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/templatized_alu_exec.sv
// ALU execution stage: arith/logic in one cycle, shifts/rotates one bit per cycle.
// Latency: out_valid 1 cycle after accept (arith/logic/illegal/zero shift), else shift-amount cycles.
// Backpressure: accepts only in IDLE; result and err held in DONE until out_ready.
module templatized_alu_exec
    import templatized_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [2:0]       en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic [3:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [3:0]         step_op;
    logic [WIDTH-1:0]   step_in;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] amt;
    logic               legal;

    // The first shift step is taken on the accept edge so that an amount of N
    // reaches DONE exactly N edges after acceptance.
    assign step_op = (state_q == IDLE) ? op_code : op_q;
    assign step_in = (state_q == IDLE) ? a : result_q;
    assign amt     = b[SHAMT_W-1:0];
    assign legal   = (op_code <= OP_ROR) && (en == exp_en(op_code));

    templatized_alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .op   (step_op),
        .din  (step_in),
        .dout (step_out)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_code;
                    state_d = DONE;
                    if (!legal) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        case (op_code)
                            OP_ADD: result_d = a + b;
                            OP_SUB: result_d = a - b;
                            OP_LT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            OP_GT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
                            OP_XOR: result_d = a ^ b;
                            default: begin
                                if (amt == '0) begin
                                    result_d = a;
                                end else begin
                                    result_d = step_out;
                                    cnt_d    = amt - CNT_ONE;
                                    if (amt != CNT_ONE) begin
                                        state_d = SHIFT;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            SHIFT: begin
                result_d = step_out;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_templatized_alu_exec.sv
// Directed-vector bench for templatized_alu_exec with hand-computed expectations.
module tb_templatized_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_code;
    logic [2:0]  en;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    templatized_alu_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .en        (en),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges to out_valid, optionally stall the consumer.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [2:0] e,
                         input logic [31:0] va, input logic [31:0] vb,
                         input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_err, input int stall);
        int lat;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        op_code  = op;
        en       = e;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            lat = i;
            if (out_valid) break;
            @(posedge clk); #1;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            a = ~a;
            b = b + 1;
            in_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_hold_res"}, result, exp_res);
            chk({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_idle_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_idle_rdy"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op_code   = 4'd0;
        en        = 3'b100;
        a         = 32'd5;
        b         = 32'd7;
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_vld", {31'b0, out_valid}, 32'd0);
            chk("rst_res", result, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        // The in_valid held across release may have been accepted; drain it.
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        do_op("add_ovf", 4'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 1, 32'h0000_0000, 1'b0, 5);
        do_op("sub",     4'd1, 3'b100, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0, 0);
        do_op("lt",      4'd2, 3'b100, 32'hFFFF_FFFE, 32'd1, 1, 32'd1, 1'b0, 0);
        do_op("gt",      4'd3, 3'b100, 32'hFFFF_FFFE, 32'd1, 1, 32'd0, 1'b0, 0);
        do_op("sar3",    4'd6, 3'b001, 32'h8000_0000, 32'h23, 3, 32'hF000_0000, 1'b0, 0);
        do_op("ror1",    4'd8, 3'b001, 32'h0000_0001, 32'h1, 1, 32'h8000_0000, 1'b0, 0);
        do_op("sll0",    4'd5, 3'b001, 32'h1234_5678, 32'h0, 1, 32'h1234_5678, 1'b0, 0);
        do_op("sll4",    4'd5, 3'b001, 32'h0000_00F1, 32'h4, 4, 32'h0000_0F10, 1'b0, 2);
        do_op("rol1",    4'd7, 3'b001, 32'h8000_0001, 32'h1, 1, 32'h0000_0003, 1'b0, 0);
        do_op("ill_op9", 4'd9, 3'b000, 32'h1111_1111, 32'h2, 1, 32'h0, 1'b1, 0);
        do_op("ill_en",  4'd0, 3'b001, 32'h1111_1111, 32'h2, 1, 32'h0, 1'b1, 0);

        // ROL by 31, aborted by reset five edges after acceptance.
        op_code  = 4'd7;
        en       = 3'b001;
        a        = 32'h0000_0001;
        b        = 32'd31;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rolrst_pre_vld", {31'b0, out_valid}, 32'd0);
        chk("rolrst_pre_rdy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rolrst_post_vld", {31'b0, out_valid}, 32'd0);
        chk("rolrst_post_res", result, 32'd0);
        chk("rolrst_post_rdy", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rolrst_never_vld", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;

        do_op("xor", 4'd4, 3'b010, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1, 32'h0F0F_0F0F, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
